// File: rtl/sram_mem_requester.sv
// MEM-stage load/store initiator for a 16-bit external SRAM: each 32-bit access is split
// into a low-half and a high-half SRAM cycle with programmable wait states, stalling via ready.
module sram_mem_requester #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [31:0]        offs;
    logic [SRAM_AW-2:0] word_idx;
    logic               last;
    logic               unused_offs_bits;

    // Addresses below BASE_ADDR simply wrap; only the low SRAM_AW-1 word-index bits are kept.
    assign offs             = ALU_Res - 32'(BASE_ADDR);
    assign word_idx         = offs[SRAM_AW:2];
    assign unused_offs_bits = ^{offs[31:SRAM_AW+1], offs[1:0]};
    assign last             = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~MEM_R_EN & ~MEM_W_EN;
                if (MEM_W_EN) begin
                    state_nxt = WR_LO;
                end else if (MEM_R_EN) begin
                    state_nxt = RD_LO;
                end
            end
            WR_LO, WR_HI: begin
                // we_n rises on the last count so address and data are stable at its rising edge.
                sram_addr   = {word_idx, (state == WR_HI)};
                sram_dq_out = (state == WR_HI) ? Val_Rm[31:16] : Val_Rm[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = last;
                cnt_nxt     = last ? 4'd0 : cnt + 4'd1;
                if (last) begin
                    state_nxt = (state == WR_LO) ? WR_HI : DONE;
                end
            end
            RD_LO, RD_HI: begin
                sram_addr = {word_idx, (state == RD_HI)};
                cnt_nxt   = last ? 4'd0 : cnt + 4'd1;
                if (last) begin
                    state_nxt = (state == RD_LO) ? RD_HI : DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == RD_LO && last) begin
            rdata[15:0] <= sram_dq_in;
        end else if (state == RD_HI && last) begin
            rdata[31:16] <= sram_dq_in;
        end
    end

    always_ff @(posedge clk) begin
        assert (WAIT_CYCLES >= 1 && WAIT_CYCLES <= 15)
            else $error("sram_mem_requester: WAIT_CYCLES=%0d outside 1..15", WAIT_CYCLES);
    end

endmodule

// File: tb/tb_sram_mem_requester.sv
// Bench for sram_mem_requester: two instances (WAIT_CYCLES 1 and 3), each with a small SRAM model,
// checked cycle by cycle against a word-level reference of the access timing and memory contents.
module tb_sram_mem_requester;

    logic        clk, rst, mem_clear;
    logic        r_en   [2];
    logic        w_en   [2];
    logic [31:0] alu    [2];
    logic [31:0] val    [2];
    logic [31:0] rdata_w[2];
    logic        ready_w[2];
    logic [17:0] saddr  [2];
    logic [15:0] dq_out [2];
    logic        oe     [2];
    logic [15:0] dq_in  [2];
    logic        we_n   [2];

    logic [15:0] sram [2][0:1023];

    logic [31:0] ref_word [logic [17:0]];
    logic [31:0] ref_rdata [2];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_mem_requester #(
            .BASE_ADDR  (1024),
            .WAIT_CYCLES(g == 0 ? 1 : 3),
            .SRAM_AW    (18)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .MEM_R_EN   (r_en[g]),
            .MEM_W_EN   (w_en[g]),
            .ALU_Res    (alu[g]),
            .Val_Rm     (val[g]),
            .rdata      (rdata_w[g]),
            .ready      (ready_w[g]),
            .sram_addr  (saddr[g]),
            .sram_dq_out(dq_out[g]),
            .sram_dq_oe (oe[g]),
            .sram_dq_in (dq_in[g]),
            .sram_we_n  (we_n[g])
        );
        assign dq_in[g] = sram[g][saddr[g][9:0]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM: a word is written on any clock edge where we_n is held low.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_clear) begin
                for (int i = 0; i < 1024; i++) sram[g][i] <= '0;
            end else if (!we_n[g]) begin
                sram[g][saddr[g][9:0]] <= dq_out[g];
            end
        end
    end

    function automatic int phase_of(int s);
        return (s == 0) ? 2 : 4;
    endfunction

    function automatic logic [17:0] key_of(int s, logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'd1024) >> 2;
        return {s[0], idx[16:0]};
    endfunction

    // {ready, sram_addr, we_n, oe, dq_out} expected in cycle k after the request appears.
    function automatic logic [36:0] exp_vec(int s, bit w, logic [31:0] a, logic [31:0] d, int k);
        int          p;
        int          c;
        logic        h;
        logic [31:0] idx;
        logic [36:0] v;
        p = phase_of(s);
        v = {1'b0, 18'd0, 1'b1, 1'b0, 16'd0};
        if (k == 2 * p + 1) begin
            v[36] = 1'b1;
        end else if (k >= 1) begin
            h   = (k > p);
            c   = (k - 1) % p;
            idx = (a - 32'd1024) >> 2;
            v[35:18] = {idx[16:0], h};
            if (w) begin
                v[17]   = (c == p - 1);
                v[16]   = 1'b1;
                v[15:0] = h ? d[31:16] : d[15:0];
            end
        end
        return v;
    endfunction

    task automatic start(input int s, input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 1'b0;
            w_en[i] = 1'b0;
        end
        w_en[s] = w;
        r_en[s] = r;
        alu[s]  = a;
        val[s]  = d;
    endtask

    task automatic check_cycles(input int s, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input int k0, input int k1);
        logic [36:0] obs, exp;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            obs = {ready_w[s], saddr[s], we_n[s], oe[s], dq_out[s]};
            exp = exp_vec(s, w, a, d, k);
            checks++;
            assert (obs === exp) else begin
                failures++;
                $error("FAIL sram_pins s=%0d addr=%h k=%0d observed=%h expected=%h", s, a, k, obs, exp);
            end
            if (k == 2 * phase_of(s) + 1) begin
                if (w) ref_word[key_of(s, a)] = d;
                else ref_rdata[s] = ref_word.exists(key_of(s, a)) ? ref_word[key_of(s, a)] : 32'd0;
            end
            if (k == 0 || k == 2 * phase_of(s) + 1) begin
                checks++;
                assert (rdata_w[s] === ref_rdata[s]) else begin
                    failures++;
                    $error("FAIL rdata s=%0d addr=%h k=%0d observed=%h expected=%h",
                           s, a, k, rdata_w[s], ref_rdata[s]);
                end
            end
        end
    endtask

    task automatic access(input int s, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d);
        start(s, w, r, a, d);
        check_cycles(s, w, a, d, 0, 2 * phase_of(s) + 1);
    endtask

    task automatic idle(input int n);
        logic [36:0] obs;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 1'b0;
            w_en[i] = 1'b0;
        end
        repeat (n) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                obs = {ready_w[s], saddr[s], we_n[s], oe[s], dq_out[s]};
                checks++;
                assert (obs === {1'b1, 18'd0, 1'b1, 1'b0, 16'd0}) else begin
                    failures++;
                    $error("FAIL idle_pins s=%0d observed=%h expected=%h", s, obs,
                           {1'b1, 18'd0, 1'b1, 1'b0, 16'd0});
                end
                checks++;
                assert (rdata_w[s] === ref_rdata[s]) else begin
                    failures++;
                    $error("FAIL idle_rdata s=%0d observed=%h expected=%h", s, rdata_w[s], ref_rdata[s]);
                end
            end
        end
    endtask

    initial begin
        int          s, sel;
        bit          w, r;
        logic [31:0] a, d;

        rst       = 1'b1;
        mem_clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_en[i]      = 1'b0;
            w_en[i]      = 1'b0;
            alu[i]       = '0;
            val[i]       = '0;
            ref_rdata[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_clear = 1'b0;

        // Reset state with no requests.
        idle(10);

        // Store then load through the WAIT_CYCLES=1 instance.
        access(0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
        access(0, 1'b0, 1'b1, 32'd1028, 32'h0);
        idle(2);

        // Simultaneous read and write requests: the write wins, rdata untouched.
        access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
        idle(1);

        // Reset during the second WR_HI cycle with the request left asserted.
        a = 32'd1036;
        d = 32'hCAFEF00D;
        start(0, 1'b1, 1'b0, a, d);
        check_cycles(0, 1'b1, a, d, 0, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        check_cycles(0, 1'b1, a, d, 4, 4);
        @(posedge clk);
        #1 rst = 1'b0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        ref_word[key_of(0, a)] = d;
        check_cycles(0, 1'b1, a, d, 0, 5);
        idle(2);

        // Back-to-back loads at WAIT_CYCLES=3 after seeding the words.
        access(1, 1'b1, 1'b0, 32'd1024, 32'hA5A50F0F);
        access(1, 1'b1, 1'b0, 32'd1032, 32'h01234567);
        idle(1);
        access(1, 1'b0, 1'b1, 32'd1024, 32'h0);
        access(1, 1'b0, 1'b1, 32'd1032, 32'h0);
        idle(2);

        // Randomized mix of loads, stores, dual requests and below-base (wrapping) addresses.
        for (int n = 0; n < 40; n++) begin
            s   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            w   = (sel <= 1);
            r   = (sel != 1);
            if ($urandom_range(0, 7) == 0) a = 32'd1024 - 32'(4 * $urandom_range(1, 4));
            else a = 32'd1024 + 32'(4 * $urandom_range(0, 31));
            d = $urandom;
            access(s, w, r, a, d);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
